rng_arbiter: RTL
================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the generator (2..8).
REQ-002 Parameter SEED, default 32'hA23A_27BB, LFSR state loaded at reset.
REQ-003 Parameter WARMUP_CYCLES, default 16, LFSR steps discarded after reset/reseed (0..255).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port req  input  NUM_REQ  level request per requester; held until granted.
REQ-007 Port gnt  output  NUM_REQ  registered one-hot grant pulse, one cycle.
REQ-008 Port rnd_data  output  32  random word, valid only in cycle gnt is nonzero.
REQ-009 Port ready  output  1  high while in SERVE state.
REQ-010 Ports seed_load (input, 1, reseed strobe) and seed (input, 32, new seed) exist only under RNG_ARB_RESEED_EN.

Function
REQ-011 Internal 32-bit LFSR step: next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
REQ-012 FSM states WARM and SERVE; reset enters WARM with warm counter = 0.
REQ-013 WARM: LFSR steps every cycle, counter increments; on counter == WARMUP_CYCLES go to SERVE; WARMUP_CYCLES = 0 enters SERVE on the first cycle after reset with no steps.
REQ-014 SERVE: LFSR steps only on cycles that issue a grant; otherwise it holds.
REQ-015 Arbitration round-robin: rr pointer p; pick the first asserted eligible req at index p, p+1, ... modulo NUM_REQ.
REQ-016 After granting index i, p becomes (i+1) mod NUM_REQ; p resets to 0 and holds when no grant.
REQ-017 Latency: req sampled high at edge N -> gnt[i] and rnd_data high/valid during cycle N+1.
REQ-018 rnd_data = LFSR value before the step taken for that grant; successive grants receive successive LFSR states, never a repeat.
REQ-019 A requester whose gnt bit is high in the current cycle is ineligible at the next edge (prevents double grant while it drops req).
REQ-020 At most one gnt bit high in any cycle; no grant issued in WARM; req during WARM waits, no loss.
REQ-021 rnd_data holds its last value when gnt = 0 (no toggling).

Reset
REQ-022 On rst: lfsr = SEED, state = WARM, warm counter = 0, p = 0, gnt = 0, rnd_data = 0, ready = 0.
REQ-023 rst asserted mid-grant clears gnt immediately (asynchronous); in-flight grant is lost, requester re-requests.
REQ-024 SEED = 0 is illegal; the block substitutes 32'hA23A_27BB.

Configuration
REQ-025 Macro RNG_ARB_RESEED_EN: defined -> seed_load/seed ports present; undefined -> ports absent, LFSR seeded only by reset.
REQ-026 With macro, seed_load high at an edge: lfsr = seed (0 replaced by 32'hA23A_27BB), state = WARM, counter = 0, p = 0, no grant that cycle; seed_load has priority over a simultaneous grant.
REQ-027 seed_load held high keeps reloading; WARM restarts when it falls.

Verification
REQ-028 WARMUP_CYCLES=0, rst release, req=4'b0001 held -> gnt=0001 with rnd_data=32'hA23A_27BB, after drop-and-reassert next grant rnd_data=32'h4474_4F76.
REQ-029 WARMUP_CYCLES=16, req=4'b1111 from reset -> ready rises after 16 cycles, grants in order 0001,0010,0100,1000,0001, one per two cycles max per requester, never two bits.
REQ-030 req=0101 continuous, each drops req the cycle after gnt -> alternating gnt 0001/0100, no double grant to one requester.
REQ-031 rst pulsed in the cycle gnt=0010 -> gnt=0 in same cycle, lfsr back to A23A_27BB, ready=0.
REQ-032 RNG_ARB_RESEED_EN, WARMUP_CYCLES=0, seed_load with seed=0 concurrent with req=0001 -> no grant that cycle, next grant rnd_data=32'hA23A_27BB.
REQ-033 No req for 100 cycles in SERVE -> lfsr and rnd_data unchanged, gnt=0 throughout.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin arbiter handing out words from a shared 32-bit LFSR.
// After reset (or a reseed) the LFSR runs WARMUP_CYCLES discarded steps in WARM.
// In SERVE it steps once per grant, so every grant gets a fresh state.
// Optional feature macro: RNG_ARB_RESEED_EN adds the seed_load/seed reseed ports.
module rng_arbiter #(
    parameter int          NUM_REQ       = 4,
    parameter logic [31:0] SEED          = 32'hA23A_27BB,
    parameter int          WARMUP_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef RNG_ARB_RESEED_EN
    input  logic               seed_load,
    input  logic [31:0]        seed,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rnd_data,
    output logic               ready
);

    // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
    localparam logic [31:0] DEFAULT_SEED = 32'hA23A_27BB;
    localparam logic [31:0] SEED_EFF     = (SEED == 32'd0) ? DEFAULT_SEED : SEED;
    localparam int          PW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int          SW           = PW + 1;
    localparam logic [7:0]  WARM_LIMIT   = 8'(WARMUP_CYCLES);

    localparam logic [0:0]  ST_WARM  = 1'b0;
    localparam logic [0:0]  ST_SERVE = 1'b1;

    logic [0:0]         r_state;
    logic [7:0]         r_warm_cnt;
    logic [31:0]        r_lfsr;
    logic [PW-1:0]      r_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [31:0]        r_rnd;

    logic [31:0]        w_lfsr_step;
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic               w_found;
    logic [PW-1:0]      w_sel;
    logic [PW-1:0]      w_ptr_next;
    logic               w_grant;
    logic               w_reload;
    logic [31:0]        w_reload_val;

`ifdef RNG_ARB_RESEED_EN
    assign w_reload     = seed_load;
    assign w_reload_val = (seed == 32'd0) ? DEFAULT_SEED : seed;
`else
    assign w_reload     = 1'b0;
    assign w_reload_val = SEED_EFF;
`endif

    assign w_lfsr_step = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    // A requester granted this cycle sits out the next edge so it cannot be
    // granted twice while it is still dropping its request.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_elig[gi]       = req[gi] & ~r_gnt[gi];
            assign w_sel_onehot[gi] = w_found && (w_sel == PW'(gi));
        end
    endgenerate

    // Round-robin search: first eligible index starting at the pointer, wrapping.
    always_comb begin
        logic [SW-1:0] v_sum;
        w_found = 1'b0;
        w_sel   = '0;
        v_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_ptr} + SW'(k);
            if (v_sum >= SW'(NUM_REQ)) begin
                v_sum = v_sum - SW'(NUM_REQ);
            end
            if (!w_found && w_elig[v_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_sum[PW-1:0];
            end
        end
    end

    assign w_ptr_next = (w_sel == PW'(NUM_REQ - 1)) ? '0 : w_sel + PW'(1);
    assign w_grant    = (r_state == ST_SERVE) && w_found && !w_reload;

    // FSM, warm-up counter and LFSR; reseed wins over everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_WARM;
            r_warm_cnt <= 8'd0;
            r_lfsr     <= SEED_EFF;
        end else if (w_reload) begin
            r_state    <= ST_WARM;
            r_warm_cnt <= 8'd0;
            r_lfsr     <= w_reload_val;
        end else if (r_state == ST_WARM) begin
            if (r_warm_cnt == WARM_LIMIT) begin
                r_state <= ST_SERVE;
            end else begin
                r_lfsr     <= w_lfsr_step;
                r_warm_cnt <= r_warm_cnt + 8'd1;
            end
        end else if (w_grant) begin
            r_lfsr <= w_lfsr_step;
        end
    end

    // Grant pulse, word capture and round-robin pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt <= '0;
            r_rnd <= 32'd0;
            r_ptr <= '0;
        end else if (w_reload) begin
            r_gnt <= '0;
            r_ptr <= '0;
        end else if (w_grant) begin
            r_gnt <= w_sel_onehot;
            r_rnd <= r_lfsr;
            r_ptr <= w_ptr_next;
        end else begin
            r_gnt <= '0;
        end
    end

    assign gnt      = r_gnt;
    assign rnd_data = r_rnd;
    assign ready    = (r_state == ST_SERVE);

endmodule
